// File: rtl/stream_demux.sv
// 1-to-NUM_CH valid/ready stream demultiplexer: one-entry buffer per channel,
// broadcast, per-channel delivery counters and a sticky out-of-range select flag.
//
//   state    | meaning
//   ---------+--------------------------------------------------
//   ST_EMPTY | channel holds no word, out_valid low
//   ST_FULL  | channel holds a word, out_valid high until taken
module stream_demux #(
    parameter int DATA_W = 8,
    parameter int NUM_CH = 4,
    parameter int SEL_W  = 2,
    parameter int CNT_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_W-1:0]        in_data,
    input  logic [SEL_W-1:0]         in_sel,
    input  logic                     in_bcast,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    output logic [NUM_CH-1:0]        out_valid,
    input  logic [NUM_CH-1:0]        out_ready,
    input  logic                     cnt_clr,
    output logic [NUM_CH*CNT_W-1:0]  ch_count,
    output logic                     err_sel
);
    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic [SEL_W:0]    sel_ext;
    logic [NUM_CH-1:0] ch_hit;
    logic [NUM_CH-1:0] ch_free;
    logic [NUM_CH-1:0] ch_wr;
    logic              sel_in_range;
    logic              accept;

    // Widened select so the range check is never a constant compare for full-width NUM_CH.
    assign sel_ext = {1'b0, in_sel};

    always_comb begin
        ch_hit = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            ch_hit[k] = (sel_ext == (SEL_W+1)'(k));
        end
    end

    assign sel_in_range = |ch_hit;

    always_comb begin
        if (in_bcast) begin
            in_ready = &ch_free;
        end else if (sel_in_range) begin
            in_ready = |(ch_hit & ch_free);
        end else begin
            in_ready = 1'b1;
        end
    end

    assign accept = in_valid & in_ready;

    always_comb begin
        ch_wr = '0;
        if (accept) begin
            ch_wr = in_bcast ? {NUM_CH{1'b1}} : ch_hit;
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic [0:0]        state;
        logic [DATA_W-1:0] data_q;
        logic [CNT_W-1:0]  cnt_q;
        logic              deliver;

        assign deliver    = (state == ST_FULL) && out_ready[k];
        assign ch_free[k] = (state == ST_EMPTY) || out_ready[k];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state  <= ST_EMPTY;
                data_q <= '0;
            end else begin
                case (state)
                    ST_EMPTY: if (ch_wr[k]) state <= ST_FULL;
                    ST_FULL:  if (out_ready[k] && !ch_wr[k]) state <= ST_EMPTY;
                    default:  state <= ST_EMPTY;
                endcase
                if (ch_wr[k]) begin
                    data_q <= in_data;
                end
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_q <= '0;
            end else if (cnt_clr) begin
                cnt_q <= '0;
            end else if (deliver) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end

        assign out_valid[k]                   = (state == ST_FULL);
        assign out_data[k*DATA_W +: DATA_W]   = data_q;
        assign ch_count[k*CNT_W +: CNT_W]     = cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_sel <= 1'b0;
        end else if (accept && !in_bcast && !sel_in_range) begin
            err_sel <= 1'b1;
        end
    end
endmodule

// File: tb/tb_stream_demux.sv
// Randomised and directed bench for stream_demux against a queue-based channel model.
module tb_stream_demux;
    localparam int NC = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  in_data = '0;
    logic [1:0]  in_sel = '0;
    logic        in_bcast = 1'b0;
    logic        in_valid = 1'b0;
    logic        cnt_clr = 1'b0;
    logic [3:0]  out_ready = '0;

    logic        in_ready;
    logic [31:0] out_data;
    logic [3:0]  out_valid;
    logic [31:0] ch_count;
    logic        err_sel;

    logic        in_ready3;
    logic [23:0] out_data3;
    logic [2:0]  out_valid3;
    logic [23:0] ch_count3;
    logic        err_sel3;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] mq[NC][$];
    int         mcnt[NC];
    bit         merr = 1'b0;
    bit         m_acc;

    stream_demux #(.DATA_W(8), .NUM_CH(4), .SEL_W(2), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_sel(in_sel), .in_bcast(in_bcast),
        .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .cnt_clr(cnt_clr), .ch_count(ch_count), .err_sel(err_sel)
    );

    stream_demux #(.DATA_W(8), .NUM_CH(3), .SEL_W(2), .CNT_W(8)) dut3 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_sel(in_sel), .in_bcast(in_bcast),
        .in_valid(in_valid), .in_ready(in_ready3), .out_data(out_data3), .out_valid(out_valid3),
        .out_ready(out_ready[2:0]), .cnt_clr(cnt_clr), .ch_count(ch_count3), .err_sel(err_sel3)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // A channel can take a word if it is empty or its consumer is taking the current one.
    function automatic bit m_ready();
        bit fr[NC];
        bit all_free = 1'b1;
        for (int k = 0; k < NC; k++) begin
            fr[k] = (mq[k].size() == 0) || out_ready[k];
            all_free &= fr[k];
        end
        if (in_bcast) return all_free;
        if (int'(in_sel) < NC) return fr[in_sel];
        return 1'b1;
    endfunction

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            for (int k = 0; k < NC; k++) begin
                mq[k].delete();
                mcnt[k] = 0;
            end
            merr = 1'b0;
        end else begin
            m_acc = in_valid && m_ready();
            for (int k = 0; k < NC; k++) begin
                if (mq[k].size() != 0 && out_ready[k]) begin
                    void'(mq[k].pop_front());
                    mcnt[k] = (mcnt[k] + 1) % 256;
                end
                if (cnt_clr) mcnt[k] = 0;
            end
            if (m_acc) begin
                if (in_bcast) begin
                    for (int k = 0; k < NC; k++) mq[k].push_back(in_data);
                end else if (int'(in_sel) < NC) begin
                    mq[in_sel].push_back(in_data);
                end else begin
                    merr = 1'b1;
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (!rst) begin
            chk("in_ready", {31'b0, in_ready}, {31'b0, m_ready()});
            chk("err_sel", {31'b0, err_sel}, {31'b0, merr});
            for (int k = 0; k < NC; k++) begin
                chk($sformatf("out_valid%0d", k), {31'b0, out_valid[k]}, {31'b0, mq[k].size() != 0});
                if (mq[k].size() != 0)
                    chk($sformatf("out_data%0d", k), {24'b0, out_data[k*8 +: 8]}, {24'b0, mq[k][0]});
                chk($sformatf("ch_count%0d", k), {24'b0, ch_count[k*8 +: 8]}, mcnt[k]);
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_out_valid", {28'b0, out_valid}, 32'h0);
        chk("rst_out_data", out_data, 32'h0);
        chk("rst_ch_count", ch_count, 32'h0);
        chk("rst_err_sel", {31'b0, err_sel}, 32'h0);

        // single word to ch2
        in_sel = 2'd2; in_data = 8'hA5; in_valid = 1'b1; out_ready = 4'hF;
        step();
        chk("t1_out_valid", {28'b0, out_valid}, 32'h4);
        chk("t1_out_data2", {24'b0, out_data[23:16]}, 32'hA5);
        in_valid = 1'b0;
        step();
        chk("t1_ch_count", ch_count, 32'h0001_0000);

        // stalled ch1, second word waits and then refills in the release cycle
        out_ready = 4'b1101; in_sel = 2'd1; in_data = 8'h11; in_valid = 1'b1;
        step();
        in_data = 8'h22;
        #1;
        chk("t2_in_ready_stall", {31'b0, in_ready}, 32'h0);
        chk("t2_hold_data", {24'b0, out_data[15:8]}, 32'h11);
        step();
        chk("t2_hold_valid", {31'b0, out_valid[1]}, 32'h1);
        chk("t2_hold_data2", {24'b0, out_data[15:8]}, 32'h11);
        out_ready = 4'hF;
        #1;
        chk("t2_in_ready_free", {31'b0, in_ready}, 32'h1);
        step();
        chk("t2_refill_valid", {31'b0, out_valid[1]}, 32'h1);
        chk("t2_refill_data", {24'b0, out_data[15:8]}, 32'h22);
        chk("t2_count1", {24'b0, ch_count[15:8]}, 32'h1);
        in_valid = 1'b0;
        step();

        // broadcast blocked by full ch0, then one accept fills all channels
        out_ready = 4'b1110; in_sel = 2'd0; in_data = 8'h55; in_valid = 1'b1;
        step();
        in_bcast = 1'b1; in_data = 8'h3C;
        #1;
        chk("t3_bcast_blocked", {31'b0, in_ready}, 32'h0);
        step();
        chk("t3_only_ch0", {28'b0, out_valid}, 32'h1);
        in_valid = 1'b0; out_ready = 4'hF;
        step();
        in_valid = 1'b1;
        step();
        chk("t3_bcast_valid", {28'b0, out_valid}, 32'hF);
        chk("t3_bcast_data", out_data, 32'h3C3C_3C3C);
        chk("t3_bcast_valid3", {29'b0, out_valid3}, 32'h7);
        in_valid = 1'b0; in_bcast = 1'b0;
        step();

        // out-of-range select on the 3-channel instance
        chk("t4_err3_before", {31'b0, err_sel3}, 32'h0);
        in_sel = 2'd3; in_data = 8'h77; in_valid = 1'b1;
        #1;
        chk("t4_in_ready3", {31'b0, in_ready3}, 32'h1);
        step();
        chk("t4_out_valid3", {29'b0, out_valid3}, 32'h0);
        chk("t4_err3_set", {31'b0, err_sel3}, 32'h1);
        in_valid = 1'b0;
        repeat (5) step();
        chk("t4_err3_sticky", {31'b0, err_sel3}, 32'h1);

        // counter wrap and clear priority
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        chk("t5_clr_all", ch_count, 32'h0);
        in_sel = 2'd0; in_valid = 1'b1;
        repeat (260) begin
            in_data = 8'($urandom);
            step();
        end
        in_valid = 1'b0;
        step();
        chk("t5_wrap", {24'b0, ch_count[7:0]}, 32'h4);
        in_valid = 1'b1;
        step();
        cnt_clr = 1'b1;
        step();
        chk("t5_clr_prio", {24'b0, ch_count[7:0]}, 32'h0);
        cnt_clr = 1'b0; in_valid = 1'b0;
        step();

        repeat (3000) begin
            in_data   = 8'($urandom);
            in_sel    = 2'($urandom);
            in_bcast  = ($urandom_range(0, 7) == 0);
            in_valid  = 1'($urandom);
            out_ready = 4'($urandom);
            cnt_clr   = ($urandom_range(0, 63) == 0);
            step();
        end

        // async reset with ch1 full
        in_valid = 1'b0; in_bcast = 1'b0; cnt_clr = 1'b0; out_ready = 4'hF;
        step();
        out_ready = 4'h0; in_sel = 2'd1; in_data = 8'h99; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("t6_ch1_full", {31'b0, out_valid[1]}, 32'h1);
        chk("t6_err3_pre", {31'b0, err_sel3}, 32'h1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_out_valid", {28'b0, out_valid}, 32'h0);
        chk("t6_ch_count", ch_count, 32'h0);
        chk("t6_out_data", out_data, 32'h0);
        chk("t6_count3", {8'b0, ch_count3}, 32'h0);
        chk("t6_data3", {8'b0, out_data3}, 32'h0);
        chk("t6_err3", {31'b0, err_sel3}, 32'h0);
        step();
        rst = 1'b0;
        repeat (3) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
